// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LANE_W     = $clog2(BYTE_LANES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    RESP    = 3'd4
  } lsu_state_e;

  // Word accesses must sit on a word boundary; byte accesses may use any lane.
  function automatic logic is_misaligned(input logic byte_acc, input logic [LANE_W-1:0] lane);
    return ~byte_acc & (lane != '0);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: zero-extended byte extract for lbu and byte merge for sb,
// both steered by the same little-endian lane select.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [LANE_W-1:0]     i_lane,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [BYTE_W-1:0]     i_wbyte,
  output logic [DATA_WIDTH-1:0] o_extract,
  output logic [DATA_WIDTH-1:0] o_merge
);

  logic [BYTE_W-1:0] w_byte;

  assign w_byte    = i_rdata[BYTE_W*i_lane +: BYTE_W];
  assign o_extract = DATA_WIDTH'(w_byte);

  always_comb begin
    o_merge = i_rdata;
    o_merge[BYTE_W*i_lane +: BYTE_W] = i_wbyte;
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit: runs lw/sw/lbu/sb on a word-only memory bus,
// doing sb as a read-modify-write and stalling the pipeline while busy.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic                  byte_address_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  req_ready_o,
  output logic                  stall_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e            r_state;
  lsu_state_e            w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_merge;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_write;
  logic                  r_byte;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_busy;
  logic                  w_rd_capture;
  logic [DATA_WIDTH-1:0] w_extract;
  logic [DATA_WIDTH-1:0] w_merge;

  assign req_ready_o  = (r_state == IDLE) & ~rst_i;
  assign w_accept     = req_valid_i & req_ready_o;
  assign w_misaligned = is_misaligned(byte_address_i, addr_i[LANE_W-1:0]);
  assign w_rd_capture = (r_state == RD_WAIT) & mem_rvalid_i;

  lsu_byte_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_lane (
    .i_lane    (r_addr[LANE_W-1:0]),
    .i_rdata   (mem_rdata_i),
    .i_wbyte   (r_wdata[BYTE_W-1:0]),
    .o_extract (w_extract),
    .o_merge   (w_merge)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state plus state-decoded bus/response strobes; all strobes drop in reset.
  always_comb begin
    w_next      = r_state;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    rsp_valid_o = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_misaligned)                       w_next = RESP;
          else if (req_write_i && !byte_address_i) w_next = WR_REQ;
          else                                     w_next = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req_o = ~rst_i;
        w_busy    = 1'b1;
        if (mem_gnt_i) w_next = RD_WAIT;
      end
      RD_WAIT: begin
        w_busy = 1'b1;
        if (mem_rvalid_i) w_next = r_write ? WR_REQ : RESP;
      end
      WR_REQ: begin
        mem_req_o = ~rst_i;
        mem_we_o  = ~rst_i;
        w_busy    = 1'b1;
        if (mem_gnt_i) w_next = RESP;
      end
      RESP: begin
        rsp_valid_o = ~rst_i;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture, load result and sb merge word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_err   <= 1'b0;
      r_merge <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        r_write <= req_write_i;
        r_byte  <= byte_address_i;
        r_err   <= w_misaligned;
      end
      if (w_rd_capture) begin
        if (r_write) r_merge <= w_merge;
        else         r_rdata <= r_byte ? w_extract : mem_rdata_i;
      end
    end
  end

  assign stall_o     = ~rst_i & ((req_valid_i & (r_state == IDLE)) | w_busy);
  assign rsp_err_o   = rsp_valid_o & r_err;
  assign rsp_rdata_o = r_rdata;
  assign mem_addr_o  = {r_addr[ADDR_WIDTH-1:LANE_W], LANE_W'(0)};
  assign mem_wdata_o = r_byte ? r_merge : r_wdata;

endmodule
